// File: rtl/uart_fifo_bridge.sv
// Byte buffering between the host register front-end and the uart core:
// a TX FIFO drained one frame at a time, an RX FIFO with a sticky overrun flag.
module uart_fifo_bridge #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       data_send,
  output logic             ena_tx,
  input  logic             tx_done,
  input  logic [7:0]       data_recv,
  input  logic             new_rx,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic             rx_overrun,
  input  logic             overrun_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_st_t;

  logic [7:0]       r_tx_mem [DEPTH];
  logic [AW-1:0]    r_tx_wp, r_tx_rp;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [7:0]       r_rx_mem [DEPTH];
  logic [AW-1:0]    r_rx_wp, r_rx_rp;
  logic [CNT_W-1:0] r_rx_cnt;
  tx_st_t           r_state, w_next;
  logic             r_ena_tx, r_ovr;
  logic [7:0]       r_data_send;
  logic             w_tx_push, w_tx_pop, w_tx_load;
  logic             w_rx_push, w_rx_pop, w_rx_full, w_ovr_set;

  // ---------------- TX FIFO ----------------
  assign wr_ready  = (r_tx_cnt != FULL);
  assign w_tx_push = wr_valid && wr_ready;

  always_ff @(posedge clk)
    if (w_tx_push) r_tx_mem[r_tx_wp] <= wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_tx_cnt != '0) w_next = SEND;
      SEND:    if (tx_done) w_next = GAP;
      GAP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_tx_load = (r_state == IDLE) && (r_tx_cnt != '0);
    w_tx_pop  = (r_state == SEND) && tx_done;
  end

  // The head stays in the FIFO until the frame completes; data_send is a snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ena_tx    <= 1'b0;
      r_data_send <= 8'h00;
    end else if (w_tx_load) begin
      r_ena_tx    <= 1'b1;
      r_data_send <= r_tx_mem[r_tx_rp];
    end else if (w_tx_pop) begin
      r_ena_tx    <= 1'b0;
    end
  end

  assign ena_tx    = r_ena_tx;
  assign data_send = r_data_send;
  assign tx_count  = r_tx_cnt;

  // ---------------- RX FIFO ----------------
  assign rd_valid  = (r_rx_cnt != '0);
  assign w_rx_pop  = rd_valid && rd_ready;
  assign w_rx_full = (r_rx_cnt == FULL);
  // A pop frees the slot this cycle, so a full FIFO may still accept.
  assign w_rx_push = new_rx && (!w_rx_full || w_rx_pop);
  assign w_ovr_set = new_rx && w_rx_full && !w_rx_pop;

  always_ff @(posedge clk)
    if (w_rx_push) r_rx_mem[r_rx_wp] <= data_recv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
      if (w_ovr_set)        r_ovr <= 1'b1;
      else if (overrun_clr) r_ovr <= 1'b0;
    end
  end

  assign rd_data    = rd_valid ? r_rx_mem[r_rx_rp] : 8'h00;
  assign rx_count   = r_rx_cnt;
  assign rx_overrun = r_ovr;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed + randomized bench for uart_fifo_bridge; a queue-based model
// tracks both FIFOs and the frame timing and is compared every cycle.
module tb_uart_fifo_bridge;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 0, rst = 1;
  logic [7:0]       wr_data = 0, data_recv = 0;
  logic             wr_valid = 0, rd_ready = 0, tx_done = 0, new_rx = 0, overrun_clr = 0;
  logic             wr_ready, rd_valid, ena_tx, rx_overrun;
  logic [7:0]       rd_data, data_send;
  logic [CNT_W-1:0] tx_count, rx_count;

  uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .data_send(data_send),
    .ena_tx(ena_tx), .tx_done(tx_done), .data_recv(data_recv), .new_rx(new_rx),
    .tx_count(tx_count), .rx_count(rx_count), .rx_overrun(rx_overrun), .overrun_clr(overrun_clr));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // reference model
  logic [7:0] txq[$], rxq[$];
  bit         m_ena, m_ovr;
  logic [7:0] m_data;
  int         m_cool;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    txq.delete(); rxq.delete();
    m_ena = 0; m_ovr = 0; m_cool = 0; m_data = 0;
  endtask

  task automatic check_all();
    chk("tx_count", 32'(tx_count), txq.size());
    chk("wr_ready", 32'(wr_ready), 32'(txq.size() != DEPTH));
    chk("ena_tx", 32'(ena_tx), 32'(m_ena));
    if (m_ena) chk("data_send", 32'(data_send), 32'(m_data));
    chk("rx_count", 32'(rx_count), rxq.size());
    chk("rd_valid", 32'(rd_valid), 32'(rxq.size() != 0));
    if (rxq.size() != 0) chk("rd_data", 32'(rd_data), 32'(rxq[0]));
    chk("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
  endtask

  // One clock: advance the model from the pre-edge inputs, then compare.
  task automatic cycle();
    int  tsz, rsz;
    bit  rpop;
    @(posedge clk);
    tsz = txq.size();
    rsz = rxq.size();
    if (rst) model_reset();
    else begin
      if (m_ena && tx_done) begin
        void'(txq.pop_front());
        m_ena  = 0;
        m_cool = 1;
      end else if (!m_ena) begin
        if (m_cool > 0) m_cool--;
        else if (tsz != 0) begin
          m_ena  = 1;
          m_data = txq[0];
        end
      end
      if (wr_valid && tsz != DEPTH) txq.push_back(wr_data);
      rpop = rd_ready && rsz != 0;
      if (rpop) void'(rxq.pop_front());
      if (new_rx && (rsz != DEPTH || rpop)) rxq.push_back(data_recv);
      if (new_rx && rsz == DEPTH && !rpop) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
    end
    #1;
    check_all();
  endtask

  task automatic wait_ena(input string tag);
    int n = 0;
    while (!ena_tx && n < 10) begin cycle(); n++; end
    chk({tag, "_timeout"}, 32'(ena_tx), 32'd1);
  endtask

  initial begin
    // reset state
    model_reset();
    cycle(); cycle();
    chk("rst_ena", 32'(ena_tx), 0);
    chk("rst_dsend", 32'(data_send), 0);
    chk("rst_rdata", 32'(rd_data), 0);
    chk("rst_txcnt", 32'(tx_count), 0);
    rst = 0;

    // single byte: latency and teardown
    wr_data = 8'hA5; wr_valid = 1; cycle();
    wr_valid = 0;
    chk("a5_noena_yet", 32'(ena_tx), 0);
    cycle();
    chk("a5_ena", 32'(ena_tx), 1);
    chk("a5_data", 32'(data_send), 32'hA5);
    tx_done = 1; cycle(); tx_done = 0;
    chk("a5_done_ena", 32'(ena_tx), 0);
    chk("a5_done_cnt", 32'(tx_count), 0);
    repeat (4) cycle();
    chk("a5_idle", 32'(ena_tx), 0);

    // fill TX, one rejected push, then drain in order
    for (int i = 1; i <= 16; i++) begin
      wr_data = 8'(i); wr_valid = 1; cycle();
    end
    chk("tx_full_cnt", 32'(tx_count), 16);
    chk("tx_full_rdy", 32'(wr_ready), 0);
    wr_data = 8'h77; cycle();
    wr_valid = 0;
    chk("tx_full_hold", 32'(tx_count), 16);
    for (int i = 1; i <= 16; i++) begin
      wait_ena("drain");
      chk("drain_order", 32'(data_send), i);
      tx_done = 1; cycle(); tx_done = 0;
      chk("drain_gap", 32'(ena_tx), 0);
    end
    repeat (3) cycle();
    chk("drain_empty", 32'(tx_count), 0);

    // two RX bytes
    new_rx = 1; data_recv = 8'h3C; cycle();
    data_recv = 8'hC3; cycle();
    new_rx = 0;
    chk("rx2_cnt", 32'(rx_count), 2);
    chk("rx2_head", 32'(rd_data), 32'h3C);
    rd_ready = 1; cycle();
    chk("rx2_second", 32'(rd_data), 32'hC3);
    cycle(); rd_ready = 0;
    chk("rx2_empty", 32'(rd_valid), 0);

    // RX overrun behaviour
    new_rx = 1;
    for (int i = 0; i < 16; i++) begin data_recv = 8'(8'h40 + i); cycle(); end
    data_recv = 8'hFF; cycle();
    new_rx = 0;
    chk("ovr_set", 32'(rx_overrun), 1);
    chk("ovr_head", 32'(rd_data), 32'h40);
    chk("ovr_cnt", 32'(rx_count), 16);
    overrun_clr = 1; cycle(); overrun_clr = 0;
    chk("ovr_clr", 32'(rx_overrun), 0);
    new_rx = 1; rd_ready = 1; data_recv = 8'hEE; cycle();
    new_rx = 0; rd_ready = 0;
    chk("ovr_pop_cnt", 32'(rx_count), 16);
    chk("ovr_pop_flag", 32'(rx_overrun), 0);
    chk("ovr_pop_head", 32'(rd_data), 32'h41);
    new_rx = 1; overrun_clr = 1; data_recv = 8'h11; cycle();
    new_rx = 0; overrun_clr = 0;
    chk("ovr_set_wins", 32'(rx_overrun), 1);

    // async reset mid-frame
    wr_valid = 1;
    for (int i = 0; i < 5; i++) begin wr_data = 8'(8'h90 + i); cycle(); end
    wr_valid = 0;
    wait_ena("rstsend");
    #1 rst = 1;
    #1;
    chk("arst_ena", 32'(ena_tx), 0);
    chk("arst_txcnt", 32'(tx_count), 0);
    chk("arst_rxcnt", 32'(rx_count), 0);
    chk("arst_ovr", 32'(rx_overrun), 0);
    model_reset();
    cycle();
    rst = 0;
    repeat (5) cycle();
    chk("arst_quiet", 32'(ena_tx), 0);

    // randomized traffic, model compared every cycle
    for (int c = 0; c < 10000; c++) begin
      int busy = (c < 5000) ? 15 : 50;
      wr_valid    = ($urandom_range(99) < 50);
      wr_data     = 8'($urandom);
      tx_done     = ($urandom_range(99) < busy);
      new_rx      = ($urandom_range(99) < 40);
      data_recv   = 8'($urandom);
      rd_ready    = ($urandom_range(99) < busy);
      overrun_clr = ($urandom_range(99) < 5);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
